mem_bus_arbiter: RTL and testbench

Shares one single-ported 64 KB byte memory (16-bit address, 8-bit data, combinational read, optional write strobe) between the CPU instruction-fetch port and data port. Each requester uses a req/ack handshake. A small FSM latches the winning request, drives the memory for WAIT_STATES+1 cycles, captures read data and pulses ack. The block sits in top between the CPU's imem/dmem buses and a single memory instance, replacing the duplicated ROM instances.

---
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported byte memory between the CPU fetch and data ports.
// Define ARB_ROUND_ROBIN_EN to replace fixed data-over-instruction priority with round-robin on ties.
module mem_bus_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int AW          = 16,
  parameter int DW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          gnt_d
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic          r_gntD;
  logic          r_iAck;
  logic          r_dAck;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_iRdata;
  logic [DW-1:0] r_dRdata;
  logic          w_pickD;
  logic          w_grant;
  logic          w_done;

`ifdef ARB_ROUND_ROBIN_EN
  // r_rrLast remembers the last owner (1=data) so a tie goes to the other port.
  logic r_rrLast;

  assign w_pickD = d_req & (~i_req | ~r_rrLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrLast <= 1'b0;
    end else if (w_grant) begin
      r_rrLast <= w_pickD;
    end
  end
`else
  assign w_pickD = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req | d_req) begin
          w_next  = S_ACCESS;
          w_grant = 1'b1;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Grant latches the winner's request; the final access edge captures data and pulses ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_gntD   <= 1'b0;
      r_iAck   <= 1'b0;
      r_dAck   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_iRdata <= '0;
      r_dRdata <= '0;
    end else begin
      r_iAck <= 1'b0;
      r_dAck <= 1'b0;
      if (w_grant) begin
        r_gntD <= w_pickD;
        r_we   <= w_pickD & d_we;
        r_cnt  <= WS;
        if (w_pickD) begin
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
        end else begin
          r_addr <= i_addr;
        end
      end else if ((r_state == S_ACCESS) && !w_done) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        if (r_gntD) begin
          r_dAck <= 1'b1;
          if (!r_we) begin
            r_dRdata <= m_rdata;
          end
        end else begin
          r_iAck   <= 1'b1;
          r_iRdata <= m_rdata;
        end
      end
    end
  end

  // Write strobe is a pure decode of registers, so reset removes it immediately.
  assign m_we    = (r_state == S_ACCESS) && r_we && (r_cnt == 4'd0);
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign busy    = (r_state == S_ACCESS);
  assign gnt_d   = r_gntD;
  assign i_ack   = r_iAck;
  assign d_ack   = r_dAck;
  assign i_rdata = r_iRdata;
  assign d_rdata = r_dRdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with one zero-wait and one three-wait instance.
// Expectations for tie-breaking follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [15:0] iAddr  = 16'h0000;
  logic [15:0] dAddr  = 16'h0000;
  logic        dWe    = 1'b0;
  logic [7:0]  dWdata = 8'h00;
  logic        iReq0  = 1'b0;
  logic        dReq0  = 1'b0;
  logic        iReq3  = 1'b0;
  logic        dReq3  = 1'b0;

  logic [7:0]  iRdata0, dRdata0, mWdata0, mRdata0;
  logic [15:0] mAddr0;
  logic        iAck0, dAck0, mWe0, busy0, gntD0;
  logic [7:0]  iRdata3, dRdata3, mWdata3, mRdata3;
  logic [15:0] mAddr3;
  logic        iAck3, dAck3, mWe3, busy3, gntD3;

  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem3 [0:65535];

  int assertCount = 0;
  int failCount   = 0;
  int weCount0    = 0;
  int dAckCount0  = 0;
  int dAckCount3  = 0;
  int protoErr    = 0;
  logic [15:0] weAddr0 = 16'h0000;
  logic [7:0]  weData0 = 8'h00;

  mem_bus_arbiter #(.WAIT_STATES(0), .AW(16), .DW(8)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(iReq0), .i_addr(iAddr), .i_rdata(iRdata0), .i_ack(iAck0),
    .d_req(dReq0), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_rdata(dRdata0), .d_ack(dAck0),
    .m_addr(mAddr0), .m_we(mWe0), .m_wdata(mWdata0), .m_rdata(mRdata0),
    .busy(busy0), .gnt_d(gntD0)
  );

  mem_bus_arbiter #(.WAIT_STATES(3), .AW(16), .DW(8)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(iReq3), .i_addr(iAddr), .i_rdata(iRdata3), .i_ack(iAck3),
    .d_req(dReq3), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_rdata(dRdata3), .d_ack(dAck3),
    .m_addr(mAddr3), .m_we(mWe3), .m_wdata(mWdata3), .m_rdata(mRdata3),
    .busy(busy3), .gnt_d(gntD3)
  );

  assign mRdata0 = mem0[mAddr0];
  assign mRdata3 = mem3[mAddr3];

  // Memory models: preload the test contents, then accept strobed writes.
  initial begin
    mem0[16'h1234] = 8'hA5;
    forever begin
      @(posedge clk);
      if (mWe0) mem0[mAddr0] <= mWdata0;
    end
  end

  initial begin
    for (int k = 0; k < 5; k++) mem3[16'h0100 + 16'(k)] = 8'h10 + 8'(k);
    forever begin
      @(posedge clk);
      if (mWe3) mem3[mAddr3] <= mWdata3;
    end
  end

  // Bus watchers sampled mid-cycle: write strobes, ack counts and ack exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (mWe0) begin
        weCount0 <= weCount0 + 1;
        weAddr0  <= mAddr0;
        weData0  <= mWdata0;
      end
      if (dAck0) dAckCount0 <= dAckCount0 + 1;
      if (dAck3) dAckCount3 <= dAckCount3 + 1;
      if ((iAck0 && dAck0) || ((iAck0 || dAck0) && busy0) ||
          (iAck3 && dAck3) || ((iAck3 || dAck3) && busy3))
        protoErr <= protoErr + 1;
    end
  end

  // Drives one transaction on the selected instance and reports cycles-to-ack (-1 on timeout).
  task automatic applyStimulus(input bit useWs3, input bit isD, input bit we,
                               input logic [15:0] addr, input logic [7:0] wdata,
                               output int cycles, output logic [7:0] rdata);
    bit done;
    bit ack;
    done   = 1'b0;
    cycles = -1;
    rdata  = 8'h00;
    @(posedge clk); #1;
    if (isD) begin
      dAddr  = addr;
      dWe    = we;
      dWdata = wdata;
      if (useWs3) dReq3 = 1'b1; else dReq0 = 1'b1;
    end else begin
      iAddr = addr;
      if (useWs3) iReq3 = 1'b1; else iReq0 = 1'b1;
    end
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      ack = useWs3 ? (isD ? dAck3 : iAck3) : (isD ? dAck0 : iAck0);
      if (ack) begin
        cycles = c;
        rdata  = useWs3 ? (isD ? dRdata3 : iRdata3) : (isD ? dRdata0 : iRdata0);
        done   = 1'b1;
      end
    end
    iReq0 = 1'b0; dReq0 = 1'b0; iReq3 = 1'b0; dReq3 = 1'b0; dWe = 1'b0;
  endtask

  task automatic test_reset();
    logic [44:0] vec;
    #12;
    vec = {iAck0, dAck0, mWe0, busy0, gntD0, iRdata0, dRdata0, mAddr0, mWdata0};
    assertCount++;
    if (vec !== 45'd0) begin failCount++; $display("[TB] FAIL reset_ws0: got %h expected 0", vec); end
    vec = {iAck3, dAck3, mWe3, busy3, gntD3, iRdata3, dRdata3, mAddr3, mWdata3};
    assertCount++;
    if (vec !== 45'd0) begin failCount++; $display("[TB] FAIL reset_ws3: got %h expected 0", vec); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int cyc;
    int dBefore;
    logic [7:0] rd;
    dBefore = dAckCount0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, cyc, rd);
    assertCount++;
    if (cyc !== 2) begin failCount++; $display("[TB] FAIL fetch_latency: got %0d expected 2", cyc); end
    assertCount++;
    if (rd !== 8'hA5) begin failCount++; $display("[TB] FAIL fetch_rdata: got %h expected a5", rd); end
    @(posedge clk); #1;
    assertCount++;
    if (iAck0 !== 1'b0) begin failCount++; $display("[TB] FAIL fetch_ack_width: got %b expected 0", iAck0); end
    assertCount++;
    if (dAckCount0 !== dBefore) begin
      failCount++; $display("[TB] FAIL fetch_no_dack: got %0d expected %0d", dAckCount0, dBefore);
    end
  endtask

  task automatic test_write();
    int cyc;
    int weBefore;
    logic [7:0] rd;
    weBefore = weCount0;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h3C, cyc, rd);
    assertCount++;
    if (cyc !== 2) begin failCount++; $display("[TB] FAIL write_latency: got %0d expected 2", cyc); end
    assertCount++;
    if (weCount0 - weBefore !== 1) begin
      failCount++; $display("[TB] FAIL write_we_cycles: got %0d expected 1", weCount0 - weBefore);
    end
    assertCount++;
    if (weAddr0 !== 16'h8000) begin failCount++; $display("[TB] FAIL write_addr: got %h expected 8000", weAddr0); end
    assertCount++;
    if (weData0 !== 8'h3C) begin failCount++; $display("[TB] FAIL write_data: got %h expected 3c", weData0); end
    assertCount++;
    if (rd !== 8'h00) begin failCount++; $display("[TB] FAIL write_drdata_kept: got %h expected 00", rd); end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00, cyc, rd);
    assertCount++;
    if (cyc !== 2) begin failCount++; $display("[TB] FAIL readback_latency: got %0d expected 2", cyc); end
    assertCount++;
    if (rd !== 8'h3C) begin failCount++; $display("[TB] FAIL readback_data: got %h expected 3c", rd); end
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h8001, 8'h55, cyc, rd);
    @(posedge clk); #1;
    assertCount++;
    if (dRdata0 !== 8'h3C) begin failCount++; $display("[TB] FAIL write2_drdata_kept: got %h expected 3c", dRdata0); end
    assertCount++;
    if (mAddr0 !== 16'h8001) begin failCount++; $display("[TB] FAIL maddr_hold: got %h expected 8001", mAddr0); end
  endtask

  task automatic test_simultaneous();
    int dCyc, iCyc, expD, expI;
    logic [7:0] dRd, iRd;
`ifdef ARB_ROUND_ROBIN_EN
    expD = 4; expI = 2;
`else
    expD = 2; expI = 4;
`endif
    dCyc = -1; iCyc = -1; dRd = 8'h00; iRd = 8'h00;
    @(posedge clk); #1;
    iAddr = 16'h1234; dAddr = 16'h8000; dWe = 1'b0;
    iReq0 = 1'b1; dReq0 = 1'b1;
    for (int c = 1; c <= 20 && (dCyc < 0 || iCyc < 0); c++) begin
      @(posedge clk); #1;
      if (dAck0) begin dCyc = c; dRd = dRdata0; dReq0 = 1'b0; end
      if (iAck0) begin iCyc = c; iRd = iRdata0; iReq0 = 1'b0; end
    end
    iReq0 = 1'b0; dReq0 = 1'b0;
    assertCount++;
    if (dCyc !== expD) begin failCount++; $display("[TB] FAIL tie_d_cycle: got %0d expected %0d", dCyc, expD); end
    assertCount++;
    if (iCyc !== expI) begin failCount++; $display("[TB] FAIL tie_i_cycle: got %0d expected %0d", iCyc, expI); end
    assertCount++;
    if (iRd !== 8'hA5) begin failCount++; $display("[TB] FAIL tie_i_rdata: got %h expected a5", iRd); end
    assertCount++;
    if (dRd !== 8'h3C) begin failCount++; $display("[TB] FAIL tie_d_rdata: got %h expected 3c", dRd); end
  endtask

  task automatic test_continuous();
    logic [3:0] pattern, expPattern;
    int acks, lastCyc;
`ifdef ARB_ROUND_ROBIN_EN
    expPattern = 4'b1010;
`else
    expPattern = 4'b1111;
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pattern = 4'b0000; acks = 0; lastCyc = -1;
    @(posedge clk); #1;
    iAddr = 16'h1234; dAddr = 16'h8000; dWe = 1'b0;
    iReq0 = 1'b1; dReq0 = 1'b1;
    for (int c = 1; c <= 30 && acks < 4; c++) begin
      @(posedge clk); #1;
      if (dAck0 || iAck0) begin
        pattern = {pattern[2:0], dAck0};
        acks++;
        lastCyc = c;
      end
    end
    iReq0 = 1'b0; dReq0 = 1'b0;
    assertCount++;
    if (pattern !== expPattern) begin
      failCount++; $display("[TB] FAIL grant_order: got %b expected %b", pattern, expPattern);
    end
    assertCount++;
    if (lastCyc !== 8) begin failCount++; $display("[TB] FAIL back_to_back_rate: got %0d expected 8", lastCyc); end
  endtask

  task automatic test_wait_states();
    int acks, busyCnt, addrBad, lastAck;
    logic [15:0] expAddr;
    logic [7:0]  expData;
    acks = 0; busyCnt = 0; addrBad = 0; lastAck = 0;
    @(posedge clk); #1;
    iAddr = 16'h0100; iReq3 = 1'b1;
    for (int c = 1; c <= 40 && acks < 5; c++) begin
      @(posedge clk); #1;
      expAddr = 16'h0100 + 16'(acks);
      if (busy3) begin
        busyCnt++;
        if (mAddr3 !== expAddr) addrBad++;
      end
      if (iAck3) begin
        expData = 8'h10 + 8'(acks);
        assertCount++;
        if (c - lastAck !== 5) begin
          failCount++; $display("[TB] FAIL ws3_ack_interval: got %0d expected 5", c - lastAck);
        end
        assertCount++;
        if (iRdata3 !== expData) begin
          failCount++; $display("[TB] FAIL ws3_rdata: got %h expected %h", iRdata3, expData);
        end
        lastAck = c;
        acks++;
        iAddr = 16'h0100 + 16'(acks);
        if (acks == 5) iReq3 = 1'b0;
      end
    end
    iReq3 = 1'b0;
    assertCount++;
    if (acks !== 5) begin failCount++; $display("[TB] FAIL ws3_ack_count: got %0d expected 5", acks); end
    assertCount++;
    if (busyCnt !== 20) begin failCount++; $display("[TB] FAIL ws3_busy_cycles: got %0d expected 20", busyCnt); end
    assertCount++;
    if (addrBad !== 0) begin failCount++; $display("[TB] FAIL ws3_maddr_stable: got %0d expected 0", addrBad); end
  endtask

  task automatic test_reset_mid();
    int dBefore, cyc;
    logic [7:0] rd;
    logic [44:0] vec;
    dBefore = dAckCount3;
    @(posedge clk); #1;
    dAddr = 16'h2000; dWdata = 8'h77; dWe = 1'b1; dReq3 = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    assertCount++;
    if (mWe3 !== 1'b1) begin failCount++; $display("[TB] FAIL abort_we_before: got %b expected 1", mWe3); end
    assertCount++;
    if (busy3 !== 1'b1) begin failCount++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy3); end
    #2 rst = 1'b1;
    #1;
    vec = {iAck3, dAck3, mWe3, busy3, gntD3, iRdata3, dRdata3, mAddr3, mWdata3};
    assertCount++;
    if (mWe3 !== 1'b0) begin failCount++; $display("[TB] FAIL abort_we_async: got %b expected 0", mWe3); end
    assertCount++;
    if (vec !== 45'd0) begin failCount++; $display("[TB] FAIL abort_outputs: got %h expected 0", vec); end
    dReq3 = 1'b0; dWe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    assertCount++;
    if (dAckCount3 !== dBefore) begin
      failCount++; $display("[TB] FAIL abort_no_ack: got %0d expected %0d", dAckCount3, dBefore);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0102, 8'h00, cyc, rd);
    assertCount++;
    if (cyc !== 5) begin failCount++; $display("[TB] FAIL after_abort_latency: got %0d expected 5", cyc); end
    assertCount++;
    if (rd !== 8'h12) begin failCount++; $display("[TB] FAIL after_abort_rdata: got %h expected 12", rd); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_simultaneous();
    test_continuous();
    test_wait_states();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    assertCount++;
    if (protoErr !== 0) begin failCount++; $display("[TB] FAIL ack_exclusive: got %0d expected 0", protoErr); end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
